// File: rtl/mul_add_pkg.sv
// Shared types and default sizing for the multiply-add / accumulate pipeline.
package mul_add_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_ACC_LEN   = 4;

    // Per-beat operation selector, carried down the pipe alongside the data
    typedef enum logic {
        MODE_MADD = 1'b0,
        MODE_ACC  = 1'b1
    } mode_t;

    // Accumulation frame tracker living in stage 2
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/mul_add_stage_reg.sv
// Generic pipeline stage: data word plus valid flag, loaded when enabled,
// cleared by synchronous active-low reset.
module mul_add_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    input  logic         d_valid,
    output logic [W-1:0] q,
    output logic         q_valid
);

    // Capture data and valid together so a held stage never splits them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/mul_add_pipe.sv
// Three-stage unsigned multiply-add / multiply-accumulate pipeline.
// Stage 1 registers A*B, C and mode; stage 2 forms the sum or runs the
// accumulation frame; stage 3 is the output register.
// Optional macro MUL_ADD_SAT_EN: clamp overflowing results to all-ones and
// flag out_sat; without it results wrap and out_sat is held at 0.
module mul_add_pipe
    import mul_add_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int ACC_LEN   = DEF_ACC_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     C,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] DATA_OUT,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 out_sat
);

    localparam int PROD_W = 2 * WIDTH;
    // One bit above the wider of product and result so overflow is visible
    localparam int EXT_W  = ((PROD_W > OUT_WIDTH) ? PROD_W : OUT_WIDTH) + 1;
    localparam int CNT_W  = $clog2(ACC_LEN);
    localparam int S1_W   = 1 + WIDTH + PROD_W;
    localparam int S3_W   = OUT_WIDTH + 2;

`ifdef MUL_ADD_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic                 advance;
    logic [PROD_W-1:0]    product;
    logic [S1_W-1:0]      s1_d;
    logic [S1_W-1:0]      s1_q;
    logic                 s1_valid;
    logic [PROD_W-1:0]    s1_prod;
    logic [WIDTH-1:0]     s1_c;
    mode_t                s1_mode;

    acc_state_t           state, state_n;
    logic [OUT_WIDTH-1:0] acc, acc_n;
    logic                 acc_sat, acc_sat_n;
    logic [CNT_W-1:0]     cnt, cnt_n;

    logic                 s2_valid, s2_valid_n;
    logic [OUT_WIDTH-1:0] s2_data, s2_data_n;
    logic                 s2_last, s2_last_n;
    logic                 s2_sat, s2_sat_n;

    logic [EXT_W-1:0]     madd_sum;
    logic                 madd_ovf;
    logic [OUT_WIDTH-1:0] madd_val;
    logic [EXT_W-1:0]     acc_sum;
    logic                 acc_sat_val;
    logic [OUT_WIDTH-1:0] acc_val;

    logic [S3_W-1:0]      s3_d;
    logic [S3_W-1:0]      s3_q;

    // The whole pipe moves in lockstep; it only freezes when a result is stuck
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    assign product = PROD_W'(A) * PROD_W'(B);
    assign s1_d    = {mode, C, product};

    mul_add_stage_reg #(.W(S1_W)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .d       (s1_d),
        .d_valid (in_valid),
        .q       (s1_q),
        .q_valid (s1_valid)
    );

    assign s1_prod = s1_q[PROD_W-1:0];
    assign s1_c    = s1_q[PROD_W+WIDTH-1:PROD_W];
    assign s1_mode = mode_t'(s1_q[S1_W-1]);

    // Candidate results; overflow only matters when saturation is built in
    assign madd_sum    = EXT_W'(s1_prod) + EXT_W'(s1_c);
    assign madd_ovf    = SAT_EN && (|madd_sum[EXT_W-1:OUT_WIDTH]);
    assign madd_val    = madd_ovf ? '1 : madd_sum[OUT_WIDTH-1:0];
    assign acc_sum     = EXT_W'(acc) + EXT_W'(s1_prod);
    assign acc_sat_val = SAT_EN && (acc_sat || (|acc_sum[EXT_W-1:OUT_WIDTH]));
    assign acc_val     = acc_sat_val ? '1 : acc_sum[OUT_WIDTH-1:0];

    // Stage 2 next-state: MADD passes through and aborts any open frame,
    // ACC accumulates and emits only on the frame's final product
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        acc_sat_n  = acc_sat;
        cnt_n      = cnt;
        s2_valid_n = s2_valid;
        s2_data_n  = s2_data;
        s2_last_n  = s2_last;
        s2_sat_n   = s2_sat;
        if (advance) begin
            s2_valid_n = 1'b0;
            if (s1_valid) begin
                if (s1_mode == MODE_MADD) begin
                    state_n    = IDLE;
                    acc_n      = '0;
                    acc_sat_n  = 1'b0;
                    cnt_n      = '0;
                    s2_valid_n = 1'b1;
                    s2_data_n  = madd_val;
                    s2_last_n  = 1'b0;
                    s2_sat_n   = madd_ovf;
                end else if (cnt == CNT_LAST) begin
                    state_n    = IDLE;
                    acc_n      = '0;
                    acc_sat_n  = 1'b0;
                    cnt_n      = '0;
                    s2_valid_n = 1'b1;
                    s2_data_n  = acc_val;
                    s2_last_n  = 1'b1;
                    s2_sat_n   = acc_sat_val;
                end else begin
                    state_n    = ACCUM;
                    acc_n      = acc_val;
                    acc_sat_n  = acc_sat_val;
                    cnt_n      = cnt + CNT_W'(1);
                end
            end
        end
    end

    // Stage 2 registers: frame state, running sum and the staged result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            acc_sat  <= 1'b0;
            cnt      <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_last  <= 1'b0;
            s2_sat   <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            acc_sat  <= acc_sat_n;
            cnt      <= cnt_n;
            s2_valid <= s2_valid_n;
            s2_data  <= s2_data_n;
            s2_last  <= s2_last_n;
            s2_sat   <= s2_sat_n;
        end
    end

    assign s3_d = {s2_data, s2_last, s2_sat};

    mul_add_stage_reg #(.W(S3_W)) u_stage3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .d       (s3_d),
        .d_valid (s2_valid),
        .q       (s3_q),
        .q_valid (out_valid)
    );

    assign DATA_OUT = s3_q[S3_W-1:2];
    assign out_last = s3_q[1];
    assign out_sat  = SAT_EN ? s3_q[0] : 1'b0;

endmodule
